// File: rtl/sklansky_adder.sv
// Registered WIDTH-bit adder built on a Sklansky parallel-prefix carry tree.
// {cout,sum} is loaded with a + b + cin on every rising clock edge, one cycle of latency.
module sklansky_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0]                bit_g;
    logic [WIDTH-1:0]                bit_p;
    logic [LEVELS:0][WIDTH-1:0]      grp_g;
    logic [LEVELS-1:0][WIDTH-1:0]    grp_p;
    logic [WIDTH-1:0]                carry;
    logic [WIDTH-1:0]                sum_next;

    assign bit_g = a & b;
    assign bit_p = a ^ b;

    // Carry-in is folded into bit 0 so every group term already spans cin.
    assign grp_g[0] = {bit_g[WIDTH-1:1], bit_g[0] | (bit_p[0] & cin)};
    assign grp_p[0] = bit_p;

    // Level k: bits with bit k of their index set absorb the group ending at
    // the top of the lower half-block; all other bits pass through unchanged.
    // The group propagate of the final level is never needed, so it is not built.
    genvar k, i;
    generate
        for (k = 0; k < LEVELS; k++) begin : g_level
            for (i = 0; i < WIDTH; i++) begin : g_bit
                if (((i >> k) & 1) == 1) begin : g_combine
                    localparam int J = ((i >> k) << k) - 1;
                    assign grp_g[k+1][i] = grp_g[k][i] | (grp_p[k][i] & grp_g[k][J]);
                    if (k < LEVELS - 1) begin : g_prop
                        assign grp_p[k+1][i] = grp_p[k][i] & grp_p[k][J];
                    end
                end else begin : g_pass
                    assign grp_g[k+1][i] = grp_g[k][i];
                    if (k < LEVELS - 1) begin : g_prop
                        assign grp_p[k+1][i] = grp_p[k][i];
                    end
                end
            end
        end
    endgenerate

    assign carry    = {grp_g[LEVELS][WIDTH-2:0], cin};
    assign sum_next = bit_p ^ carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_next;
            cout <= grp_g[LEVELS][WIDTH-1];
        end
    end

endmodule

// File: tb/tb_sklansky_adder.sv
// Directed and random checks of sklansky_adder (WIDTH=16): async reset,
// one-cycle latency, carry corner cases and mid-stream reset.
module tb_sklansky_adder;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks;
    int errors;

    sklansky_adder #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .cin  (cin),
        .a    (a),
        .b    (b),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WIDTH:0] observed,
                               input logic [WIDTH:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one vector between edges, let one rising edge load it, sample after it.
    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vcin);
        a   = va;
        b   = vb;
        cin = vcin;
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] vec_a   [12];
    logic [WIDTH-1:0] vec_b   [12];
    logic             vec_cin [12];
    logic [WIDTH:0]   vec_exp [12];

    initial begin
        checks = 0;
        errors = 0;

        vec_a[0]  = 16'd60000; vec_b[0]  = 16'd5000;  vec_cin[0]  = 1'b0; vec_exp[0]  = 17'h0FDE8;
        vec_a[1]  = 16'd3000;  vec_b[1]  = 16'd3000;  vec_cin[1]  = 1'b0; vec_exp[1]  = 17'h01770;
        vec_a[2]  = 16'd2048;  vec_b[2]  = 16'd1024;  vec_cin[2]  = 1'b0; vec_exp[2]  = 17'h00C00;
        vec_a[3]  = 16'hFFFF;  vec_b[3]  = 16'h0000;  vec_cin[3]  = 1'b1; vec_exp[3]  = 17'h10000;
        vec_a[4]  = 16'hFFFF;  vec_b[4]  = 16'hFFFF;  vec_cin[4]  = 1'b1; vec_exp[4]  = 17'h1FFFF;
        vec_a[5]  = 16'hAAAA;  vec_b[5]  = 16'h5555;  vec_cin[5]  = 1'b0; vec_exp[5]  = 17'h0FFFF;
        vec_a[6]  = 16'hAAAA;  vec_b[6]  = 16'h5555;  vec_cin[6]  = 1'b1; vec_exp[6]  = 17'h10000;
        vec_a[7]  = 16'h0001;  vec_b[7]  = 16'hFFFF;  vec_cin[7]  = 1'b0; vec_exp[7]  = 17'h10000;
        vec_a[8]  = 16'h8000;  vec_b[8]  = 16'hFFFF;  vec_cin[8]  = 1'b0; vec_exp[8]  = 17'h17FFF;
        vec_a[9]  = 16'h0100;  vec_b[9]  = 16'hFFFF;  vec_cin[9]  = 1'b1; vec_exp[9]  = 17'h10100;
        vec_a[10] = 16'h1234;  vec_b[10] = 16'h4321;  vec_cin[10] = 1'b0; vec_exp[10] = 17'h05555;
        vec_a[11] = 16'h7FFF;  vec_b[11] = 16'h0001;  vec_cin[11] = 1'b0; vec_exp[11] = 17'h08000;

        // Reset is asserted before the first clock edge with live inputs.
        rst = 1'b1;
        a   = 16'h1234;
        b   = 16'h5678;
        cin = 1'b1;
        #2;
        checkOutput("reset_async", {cout, sum}, 17'h00000);
        @(posedge clk);
        #1;
        checkOutput("reset_hold", {cout, sum}, 17'h00000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("first_after_reset", {cout, sum}, 17'h068AD);

        // Back-to-back directed vectors, one per clock.
        for (int n = 0; n < 12; n++) begin
            applyStimulus(vec_a[n], vec_b[n], vec_cin[n]);
            checkOutput($sformatf("vec%0d", n), {cout, sum}, vec_exp[n]);
        end

        // Mid-stream reset clears immediately and discards the pending result.
        applyStimulus(16'h00FF, 16'h0F0F, 1'b1);
        checkOutput("pre_reset", {cout, sum}, 17'h0100F);
        a   = 16'hFFFF;
        b   = 16'h0002;
        cin = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midstream_reset", {cout, sum}, 17'h00000);
        @(posedge clk);
        #1;
        checkOutput("midstream_hold", {cout, sum}, 17'h00000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("resume", {cout, sum}, 17'h10001);

        // Random vectors against plain integer addition.
        for (int n = 0; n < 2000; n++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rc;
            logic [WIDTH:0]   expv;
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rc   = 1'($urandom_range(0, 1));
            expv = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            applyStimulus(ra, rb, rc);
            checkOutput("random", {cout, sum}, expv);
        end

        // Single set bit in a against all-ones b.
        for (int n = 0; n < WIDTH; n++) begin
            logic [WIDTH-1:0] onehot;
            logic [WIDTH:0]   expv;
            onehot = '0;
            onehot[n] = 1'b1;
            expv = {1'b0, onehot} + {1'b0, {WIDTH{1'b1}}};
            applyStimulus(onehot, {WIDTH{1'b1}}, 1'b0);
            checkOutput($sformatf("onehot%0d", n), {cout, sum}, expv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
